// File: rtl/dadd_pkg.sv
// Shared widths and the result record carried from the dadd datapath to writeback.
package dadd_pkg;

  localparam int DADD_DATA_W = 32;
  localparam int DADD_ADDR_W = 8;

  typedef struct packed {
    logic [DADD_ADDR_W-1:0] addr;
    logic [DADD_DATA_W-1:0] data;
  } dadd_rslt_t;

endpackage

// File: rtl/dadd_sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO; the head entry is always
// presented on rd_data, and the caller must never push when full without a pop.
module dadd_sync_fifo
  import dadd_pkg::*;
#(
  parameter  int WIDTH = DADD_ADDR_W + DADD_DATA_W,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    cnt,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit so equal indices can mean full or empty.
  logic [AW:0]   wr_ptr_reg, wr_ptr_next;
  logic [AW:0]   rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          full_reg, full_next;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    cnt_next    = cnt_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + (AW+1)'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + (AW+1)'(1);
    end
    if (push && !pop) begin
      cnt_next = cnt_reg + CW'(1);
    end else if (pop && !push) begin
      cnt_next = cnt_reg - CW'(1);
    end
    full_next = (cnt_next == CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
      full_reg   <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      cnt_reg    <= cnt_next;
      full_reg   <= full_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr_reg[AW-1:0]];
  assign cnt     = cnt_reg;
  assign full    = full_reg;
  assign empty   = (cnt_reg == '0);

endmodule

// File: rtl/dadd_rslt_fifo.sv
// Captures dadd results into a FIFO for writeback; the core cannot be stalled,
// so results arriving while full are dropped and counted.
module dadd_rslt_fifo
  import dadd_pkg::*;
#(
  parameter int DATA_W = DADD_DATA_W,
  parameter int ADDR_W = DADD_ADDR_W,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dadd_out_en,
  input  logic [ADDR_W-1:0]        dadd_out_addr,
  input  logic [DATA_W-1:0]        dadd_out,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [ADDR_W-1:0]        wb_addr,
  output logic [DATA_W-1:0]        wb_data,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic                     fifo_full,
  output logic                     ovf_sticky,
  input  logic                     ovf_clr,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int W = ADDR_W + DATA_W;

  logic [W-1:0]       head;
  logic               fifo_empty;
  logic               pop, push, drop;
  logic               ovf_reg;
  logic [CNT_W-1:0]   drop_cnt_reg;

  assign pop  = wb_valid && wb_ready;
  assign push = dadd_out_en && (!fifo_full || pop);
  assign drop = dadd_out_en && fifo_full && !pop;

  dadd_sync_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data ({dadd_out_addr, dadd_out}),
    .pop     (pop),
    .rd_data (head),
    .cnt     (fifo_cnt),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Storage is not reset, so the head is masked to keep outputs clean when empty.
  assign wb_valid = !fifo_empty;
  assign wb_addr  = fifo_empty ? '0 : head[W-1 -: ADDR_W];
  assign wb_data  = fifo_empty ? '0 : head[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_reg      <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      if (drop) begin
        ovf_reg <= 1'b1;
      end else if (ovf_clr) begin
        ovf_reg <= 1'b0;
      end
      if (drop && (drop_cnt_reg != '1)) begin
        drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign ovf_sticky = ovf_reg;
  assign drop_cnt   = drop_cnt_reg;

endmodule

// File: tb/tb_dadd_rslt_fifo.sv
// Scoreboard bench for dadd_rslt_fifo: a queue model predicts occupancy, head,
// drop count and sticky flag, compared one cycle at a time.
module tb_dadd_rslt_fifo;
  import dadd_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   dadd_out_en = 1'b0;
  logic [DADD_ADDR_W-1:0] dadd_out_addr = '0;
  logic [DADD_DATA_W-1:0] dadd_out = '0;
  logic                   wb_valid;
  logic                   wb_ready = 1'b0;
  logic [DADD_ADDR_W-1:0] wb_addr;
  logic [DADD_DATA_W-1:0] wb_data;
  logic [CW-1:0]          fifo_cnt;
  logic                   fifo_full;
  logic                   ovf_sticky;
  logic                   ovf_clr = 1'b0;
  logic [CNT_W-1:0]       drop_cnt;

  dadd_rslt_fifo #(
    .DATA_W (DADD_DATA_W),
    .ADDR_W (DADD_ADDR_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .dadd_out_en   (dadd_out_en),
    .dadd_out_addr (dadd_out_addr),
    .dadd_out      (dadd_out),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .fifo_cnt      (fifo_cnt),
    .fifo_full     (fifo_full),
    .ovf_sticky    (ovf_sticky),
    .ovf_clr       (ovf_clr),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  dadd_rslt_t sb[$];
  int         m_drop = 0;
  logic       m_ovf = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Update the model from the inputs driven this cycle, clock once, then compare.
  task automatic tick();
    bit         m_full, m_pop;
    dadd_rslt_t e;
    if (rst) begin
      sb.delete();
      m_drop = 0;
      m_ovf  = 1'b0;
    end else begin
      m_full = (sb.size() == DEPTH);
      m_pop  = (sb.size() != 0) && wb_ready;
      if (m_pop) begin
        e = sb.pop_front();
        $display("pop  addr=%02h data=%08h", e.addr, e.data);
      end
      if (dadd_out_en) begin
        if (!m_full || m_pop) begin
          sb.push_back('{addr: dadd_out_addr, data: dadd_out});
          $display("push addr=%02h data=%08h", dadd_out_addr, dadd_out);
        end else begin
          if (m_drop < SAT) m_drop++;
          m_ovf = 1'b1;
          $display("drop addr=%02h data=%08h", dadd_out_addr, dadd_out);
        end
      end
      if (ovf_clr && !(dadd_out_en && m_full && !m_pop)) m_ovf = 1'b0;
    end
    @(posedge clk);
    #1;
    check("fifo_cnt", 64'(fifo_cnt), 64'(sb.size()));
    check("fifo_full", 64'(fifo_full), 64'(sb.size() == DEPTH));
    check("wb_valid", 64'(wb_valid), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      check("wb_addr", 64'(wb_addr), 64'(sb[0].addr));
      check("wb_data", 64'(wb_data), 64'(sb[0].data));
    end else begin
      check("wb_addr_zero", 64'(wb_addr), 64'd0);
      check("wb_data_zero", 64'(wb_data), 64'd0);
    end
    check("ovf_sticky", 64'(ovf_sticky), 64'(m_ovf));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
  endtask

  task automatic push1(input logic [7:0] a, input logic [31:0] d);
    dadd_out_en   = 1'b1;
    dadd_out_addr = a;
    dadd_out      = d;
    tick();
    dadd_out_en   = 1'b0;
  endtask

  task automatic fill8();
    for (int i = 0; i < 8; i++) push1(8'(8'h10 + i), 32'(i));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset held for two cycles
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    push1(8'h05, 32'h1234);
    wb_ready = 1'b1;
    idle(2);

    // Fill and drain in order
    wb_ready = 1'b0;
    fill8();
    check("full_after_fill", 64'(fifo_full), 64'd1);
    // Overflow: three drops, contents preserved
    for (int i = 0; i < 3; i++) push1(8'hEE, 32'hDEAD_0000 + 32'(i));
    check("drop_cnt_3", 64'(drop_cnt), 64'd3);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", 64'(ovf_sticky), 64'd0);
    wb_ready = 1'b1;
    idle(9);

    // Full with simultaneous push and pop
    wb_ready = 1'b0;
    fill8();
    wb_ready = 1'b1;
    push1(8'h20, 32'hAA);
    idle(9);

    // Backpressure stability on the head entry
    wb_ready = 1'b0;
    push1(8'h30, 32'h55);
    push1(8'h31, 32'h66);
    wb_ready = 1'b0; tick();
    wb_ready = 1'b0; tick();
    wb_ready = 1'b1; tick();
    idle(2);

    // Drop counter saturation and clear colliding with a drop
    wb_ready = 1'b0;
    fill8();
    for (int i = 0; i < SAT + 4; i++) push1(8'hF0, 32'(i));
    dadd_out_en = 1'b1;
    ovf_clr     = 1'b1;
    tick();
    dadd_out_en = 1'b0;
    ovf_clr     = 1'b0;
    check("sticky_set_wins", 64'(ovf_sticky), 64'd1);
    check("drop_saturated", 64'(drop_cnt), 64'(SAT));

    // Reset mid-operation with a colliding push
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) push1(8'h40 + 8'(i), 32'h100 + 32'(i));
    rst = 1'b1;
    push1(8'h4F, 32'hBAD);
    rst = 1'b0;
    check("mid_rst_cnt", 64'(fifo_cnt), 64'd0);
    check("mid_rst_drop", 64'(drop_cnt), 64'd0);
    idle(1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      dadd_out_en   = 1'($urandom_range(0, 1));
      dadd_out_addr = 8'($urandom);
      dadd_out      = $urandom;
      wb_ready      = ($urandom_range(0, 2) != 0) ? 1'b0 : 1'b1;
      ovf_clr       = ($urandom_range(0, 15) == 0);
      rst           = ($urandom_range(0, 99) == 0);
      tick();
    end
    dadd_out_en = 1'b0;
    ovf_clr     = 1'b0;
    rst         = 1'b0;
    wb_ready    = 1'b1;
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
